axi_grid_mni_w_order: RTL and testbench

Ingress ordering stage directly upstream of the grid master network interface (`axi_grid_mni`). Takes grid-side AW and W traffic that may come from several source nodes with interleaved W beats. Holds AW headers in a small queue and issues them to the MNI in arrival order. Forwards W beats only when they belong to the oldest outstanding AW, so the MNI always receives W bursts in AW order with a correctly generated `last`.

---
 rtl/axi_grid_mni_w_order.sv | 123 ++++++++++++
 tb/tb_axi_grid_mni_w_order.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/axi_grid_mni_w_order.sv
// Orders grid AW/W traffic for the MNI: AW headers queue in arrival order, W beats pass only for the oldest issued AW.
// AW: one cycle registered; W: zero-cycle combinational gate; non-matching W sources stall (never dropped).
module axi_grid_mni_w_order #(
    parameter int SRC_W = 4,
    parameter int AWP_W = 64,
    parameter int WP_W  = 72,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             s_aw_valid_i,
    output logic             s_aw_ready_o,
    input  logic [SRC_W-1:0] s_aw_src_i,
    input  logic [7:0]       s_aw_len_i,
    input  logic [AWP_W-1:0] s_aw_pl_i,
    input  logic             s_w_valid_i,
    output logic             s_w_ready_o,
    input  logic [SRC_W-1:0] s_w_src_i,
    input  logic             s_w_last_i,
    input  logic [WP_W-1:0]  s_w_pl_i,
    output logic             m_aw_valid_o,
    input  logic             m_aw_ready_i,
    output logic [SRC_W-1:0] m_aw_src_o,
    output logic [7:0]       m_aw_len_o,
    output logic [AWP_W-1:0] m_aw_pl_o,
    output logic             m_w_valid_o,
    input  logic             m_w_ready_i,
    output logic [WP_W-1:0]  m_w_pl_o,
    output logic             m_w_last_o,
    output logic             err_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]        tail_q, tail_d, iss_q, iss_d, head_q, head_d;
    logic [7:0]         beat_q, beat_d;
    logic               err_q, err_d;
    logic [DEPTH-1:0]   issued_q, issued_d;
    logic [SRC_W-1:0]   src_q [DEPTH];
    logic [7:0]         len_q [DEPTH];
    logic [AWP_W-1:0]   pl_q  [DEPTH];

    logic [PW-1:0]      tail_idx, iss_idx, head_idx;
    logic               full, head_vld, match;
    logic               aw_push, aw_iss, w_fire;

    assign tail_idx = tail_q[PW-1:0];
    assign iss_idx  = iss_q[PW-1:0];
    assign head_idx = head_q[PW-1:0];

    // Full when the wrap bits differ but the indices coincide.
    assign full     = (tail_q[PW] != head_q[PW]) && (tail_idx == head_idx);
    assign head_vld = (head_q != tail_q);
    assign match    = head_vld && issued_q[head_idx] && (s_w_src_i == src_q[head_idx]);

    assign s_aw_ready_o = !full;
    assign m_aw_valid_o = (iss_q != tail_q);
    assign m_aw_src_o   = src_q[iss_idx];
    assign m_aw_len_o   = len_q[iss_idx];
    assign m_aw_pl_o    = pl_q[iss_idx];

    assign m_w_valid_o  = s_w_valid_i && match;
    assign s_w_ready_o  = m_w_ready_i && match;
    assign m_w_pl_o     = s_w_pl_i;
    assign m_w_last_o   = head_vld && (beat_q == len_q[head_idx]);
    assign err_o        = err_q;

    assign aw_push = s_aw_valid_i && s_aw_ready_o;
    assign aw_iss  = m_aw_valid_o && m_aw_ready_i;
    assign w_fire  = m_w_valid_o && m_w_ready_i;

    always_comb begin
        tail_d   = tail_q;
        iss_d    = iss_q;
        head_d   = head_q;
        beat_d   = beat_q;
        err_d    = err_q;
        issued_d = issued_q;
        if (aw_push) begin
            tail_d             = tail_q + 1'b1;
            issued_d[tail_idx] = 1'b0;
        end
        if (aw_iss) begin
            iss_d             = iss_q + 1'b1;
            issued_d[iss_idx] = 1'b1;
        end
        if (w_fire) begin
            if (s_w_last_i != m_w_last_o) err_d = 1'b1;
            if (m_w_last_o) begin
                beat_d = 8'd0;
                head_d = head_q + 1'b1;
            end else begin
                beat_d = beat_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tail_q   <= '0;
            iss_q    <= '0;
            head_q   <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
            issued_q <= '0;
        end else begin
            tail_q   <= tail_d;
            iss_q    <= iss_d;
            head_q   <= head_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            issued_q <= issued_d;
        end
    end

    // Entry payloads need no reset: the issued bit and pointers qualify them.
    always_ff @(posedge clk_i) begin
        if (aw_push) begin
            src_q[tail_idx] <= s_aw_src_i;
            len_q[tail_idx] <= s_aw_len_i;
            pl_q[tail_idx]  <= s_aw_pl_i;
        end
    end
endmodule

// File: tb/tb_axi_grid_mni_w_order.sv
// Table-driven bench for axi_grid_mni_w_order: one row per cycle, inputs applied at negedge, outputs sampled 1ns later.
module tb_axi_grid_mni_w_order;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        s_aw_valid_i, s_aw_ready_o;
    logic [3:0]  s_aw_src_i;
    logic [7:0]  s_aw_len_i;
    logic [63:0] s_aw_pl_i;
    logic        s_w_valid_i, s_w_ready_o;
    logic [3:0]  s_w_src_i;
    logic        s_w_last_i;
    logic [71:0] s_w_pl_i;
    logic        m_aw_valid_o, m_aw_ready_i;
    logic [3:0]  m_aw_src_o;
    logic [7:0]  m_aw_len_o;
    logic [63:0] m_aw_pl_o;
    logic        m_w_valid_o, m_w_ready_i;
    logic [71:0] m_w_pl_o;
    logic        m_w_last_o, err_o;

    int checks   = 0;
    int failures = 0;

    axi_grid_mni_w_order dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_aw_valid_i(s_aw_valid_i), .s_aw_ready_o(s_aw_ready_o),
        .s_aw_src_i(s_aw_src_i), .s_aw_len_i(s_aw_len_i), .s_aw_pl_i(s_aw_pl_i),
        .s_w_valid_i(s_w_valid_i), .s_w_ready_o(s_w_ready_o),
        .s_w_src_i(s_w_src_i), .s_w_last_i(s_w_last_i), .s_w_pl_i(s_w_pl_i),
        .m_aw_valid_o(m_aw_valid_o), .m_aw_ready_i(m_aw_ready_i),
        .m_aw_src_o(m_aw_src_o), .m_aw_len_o(m_aw_len_o), .m_aw_pl_o(m_aw_pl_o),
        .m_w_valid_o(m_w_valid_o), .m_w_ready_i(m_w_ready_i),
        .m_w_pl_o(m_w_pl_o), .m_w_last_o(m_w_last_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst, chk;
        logic       awv; logic [3:0] aws; logic [7:0] awl; logic mawr;
        logic       wv;  logic [3:0] ws;  logic wl;        logic mwr;
        logic       e_awr, e_mawv; logic [3:0] e_src; logic [7:0] e_len;
        logic       e_mwv, e_swr, e_last, e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] aw_pl(input logic [3:0] s, input logic [7:0] l);
        return {32'hC0DE_F00D, 20'h0, s, l};
    endfunction

    task automatic add(input logic rst, chk, awv, input logic [3:0] aws, input logic [7:0] awl,
                       input logic mawr, wv, input logic [3:0] ws, input logic wl, mwr,
                       input logic e_awr, e_mawv, input logic [3:0] e_src, input logic [7:0] e_len,
                       input logic e_mwv, e_swr, e_last, e_err);
        vec_t v;
        v = '{rst, chk, awv, aws, awl, mawr, wv, ws, wl, mwr,
              e_awr, e_mawv, e_src, e_len, e_mwv, e_swr, e_last, e_err};
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic awv, input logic [3:0] aws, input logic [7:0] awl, input logic mawr,
                         input logic wv, input logic [3:0] ws, input logic wl, input logic mwr);
        rst_i        = 1'b0;
        s_aw_valid_i = awv; s_aw_src_i = aws; s_aw_len_i = awl; s_aw_pl_i = aw_pl(aws, awl);
        m_aw_ready_i = mawr;
        s_w_valid_i  = wv;  s_w_src_i = ws;   s_w_last_i = wl;  m_w_ready_i = mwr;
        s_w_pl_i     = {8'h5A, 32'h0, 28'h0, ws, 4'h0};
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        //   rst chk awv aws  awl  mawr wv ws  wl mwr | awr mawv src  len  mwv swr last err
        // reset and idle
        add(1, 0, 0, 4'h0, 8'd0, 0, 0, 4'h0, 0, 0,  1, 0, 4'h0, 8'd0, 0, 0, 0, 0);
        add(1, 1, 0, 4'h0, 8'd0, 0, 0, 4'h0, 0, 0,  1, 0, 4'h0, 8'd0, 0, 0, 0, 0);
        add(0, 1, 0, 4'h0, 8'd0, 0, 0, 4'h0, 0, 1,  1, 0, 4'h0, 8'd0, 0, 0, 0, 0);
        // single burst src3 len3, W gated until issued
        add(0, 1, 1, 4'h3, 8'd3, 0, 0, 4'h0, 0, 1,  1, 0, 4'h0, 8'd0, 0, 0, 0, 0);
        add(0, 1, 0, 4'h0, 8'd0, 1, 1, 4'h3, 0, 1,  1, 1, 4'h3, 8'd3, 0, 0, 0, 0);
        add(0, 1, 0, 4'h0, 8'd0, 1, 1, 4'h3, 0, 1,  1, 0, 4'h0, 8'd0, 1, 1, 0, 0);
        add(0, 1, 0, 4'h0, 8'd0, 1, 1, 4'h3, 0, 1,  1, 0, 4'h0, 8'd0, 1, 1, 0, 0);
        add(0, 1, 0, 4'h0, 8'd0, 1, 1, 4'h3, 0, 1,  1, 0, 4'h0, 8'd0, 1, 1, 0, 0);
        add(0, 1, 0, 4'h0, 8'd0, 1, 1, 4'h3, 1, 1,  1, 0, 4'h0, 8'd0, 1, 1, 1, 0);
        add(0, 1, 0, 4'h0, 8'd0, 1, 1, 4'h3, 0, 1,  1, 0, 4'h0, 8'd0, 0, 0, 0, 0);
        // interleaved: src1 len1 then src2 len0, src2 beat presented first
        add(0, 1, 1, 4'h1, 8'd1, 1, 1, 4'h2, 1, 1,  1, 0, 4'h0, 8'd0, 0, 0, 0, 0);
        add(0, 1, 1, 4'h2, 8'd0, 1, 1, 4'h2, 1, 1,  1, 1, 4'h1, 8'd1, 0, 0, 0, 0);
        add(0, 1, 0, 4'h0, 8'd0, 1, 1, 4'h2, 1, 1,  1, 1, 4'h2, 8'd0, 0, 0, 0, 0);
        add(0, 1, 0, 4'h0, 8'd0, 1, 1, 4'h2, 1, 1,  1, 0, 4'h0, 8'd0, 0, 0, 0, 0);
        add(0, 1, 0, 4'h0, 8'd0, 1, 1, 4'h1, 0, 1,  1, 0, 4'h0, 8'd0, 1, 1, 0, 0);
        add(0, 1, 0, 4'h0, 8'd0, 1, 1, 4'h1, 1, 1,  1, 0, 4'h0, 8'd0, 1, 1, 1, 0);
        add(0, 1, 0, 4'h0, 8'd0, 1, 1, 4'h2, 1, 0,  1, 0, 4'h0, 8'd0, 1, 0, 1, 0);
        add(0, 1, 0, 4'h0, 8'd0, 1, 1, 4'h2, 1, 1,  1, 0, 4'h0, 8'd0, 1, 1, 1, 0);
        add(0, 1, 0, 4'h0, 8'd0, 0, 0, 4'h0, 0, 1,  1, 0, 4'h0, 8'd0, 0, 0, 0, 0);
        // full queue with m_aw stalled, then free one entry
        add(0, 1, 1, 4'h4, 8'd1, 0, 0, 4'h0, 0, 1,  1, 0, 4'h0, 8'd0, 0, 0, 0, 0);
        add(0, 1, 1, 4'h5, 8'd0, 0, 0, 4'h0, 0, 1,  1, 1, 4'h4, 8'd1, 0, 0, 0, 0);
        add(0, 1, 1, 4'h6, 8'd0, 0, 0, 4'h0, 0, 1,  1, 1, 4'h4, 8'd1, 0, 0, 0, 0);
        add(0, 1, 1, 4'h7, 8'd0, 0, 0, 4'h0, 0, 1,  1, 1, 4'h4, 8'd1, 0, 0, 0, 0);
        add(0, 1, 1, 4'h8, 8'd0, 0, 0, 4'h0, 0, 1,  0, 1, 4'h4, 8'd1, 0, 0, 0, 0);
        add(0, 1, 1, 4'h8, 8'd0, 1, 1, 4'h4, 0, 1,  0, 1, 4'h4, 8'd1, 0, 0, 0, 0);
        add(0, 1, 1, 4'h8, 8'd0, 0, 1, 4'h4, 0, 1,  0, 1, 4'h5, 8'd0, 1, 1, 0, 0);
        add(0, 1, 1, 4'h8, 8'd0, 0, 1, 4'h4, 1, 1,  0, 1, 4'h5, 8'd0, 1, 1, 1, 0);
        add(0, 1, 1, 4'h8, 8'd0, 0, 0, 4'h0, 0, 1,  1, 1, 4'h5, 8'd0, 0, 0, 1, 0);
        add(0, 1, 0, 4'h0, 8'd0, 0, 0, 4'h0, 0, 1,  0, 1, 4'h5, 8'd0, 0, 0, 1, 0);
        add(1, 0, 0, 4'h0, 8'd0, 0, 0, 4'h0, 0, 0,  1, 0, 4'h0, 8'd0, 0, 0, 0, 0);
        add(0, 1, 0, 4'h0, 8'd0, 0, 0, 4'h0, 0, 1,  1, 0, 4'h0, 8'd0, 0, 0, 0, 0);
        // last mismatch: len1, sender flags last on beat 1
        add(0, 1, 1, 4'h9, 8'd1, 1, 0, 4'h0, 0, 1,  1, 0, 4'h0, 8'd0, 0, 0, 0, 0);
        add(0, 1, 0, 4'h0, 8'd0, 1, 0, 4'h0, 0, 1,  1, 1, 4'h9, 8'd1, 0, 0, 0, 0);
        add(0, 1, 0, 4'h0, 8'd0, 0, 1, 4'h9, 1, 1,  1, 0, 4'h0, 8'd0, 1, 1, 0, 0);
        add(0, 1, 0, 4'h0, 8'd0, 0, 1, 4'h9, 1, 1,  1, 0, 4'h0, 8'd0, 1, 1, 1, 1);
        add(0, 1, 0, 4'h0, 8'd0, 0, 0, 4'h0, 0, 1,  1, 0, 4'h0, 8'd0, 0, 0, 0, 1);
        // reset after 2 of 4 beats, then a clean len0 burst
        add(0, 1, 1, 4'hA, 8'd3, 1, 0, 4'h0, 0, 1,  1, 0, 4'h0, 8'd0, 0, 0, 0, 1);
        add(0, 1, 0, 4'h0, 8'd0, 1, 0, 4'h0, 0, 1,  1, 1, 4'hA, 8'd3, 0, 0, 0, 1);
        add(0, 1, 0, 4'h0, 8'd0, 0, 1, 4'hA, 0, 1,  1, 0, 4'h0, 8'd0, 1, 1, 0, 1);
        add(0, 1, 0, 4'h0, 8'd0, 0, 1, 4'hA, 0, 1,  1, 0, 4'h0, 8'd0, 1, 1, 0, 1);
        add(1, 0, 0, 4'h0, 8'd0, 0, 0, 4'h0, 0, 0,  1, 0, 4'h0, 8'd0, 0, 0, 0, 0);
        add(0, 1, 0, 4'h0, 8'd0, 0, 0, 4'h0, 0, 1,  1, 0, 4'h0, 8'd0, 0, 0, 0, 0);
        add(0, 1, 1, 4'hB, 8'd0, 1, 0, 4'h0, 0, 1,  1, 0, 4'h0, 8'd0, 0, 0, 0, 0);
        add(0, 1, 0, 4'h0, 8'd0, 1, 0, 4'h0, 0, 1,  1, 1, 4'hB, 8'd0, 0, 0, 1, 0);
        add(0, 1, 0, 4'h0, 8'd0, 0, 1, 4'hB, 1, 1,  1, 0, 4'h0, 8'd0, 1, 1, 1, 0);
        add(0, 1, 0, 4'h0, 8'd0, 0, 0, 4'h0, 0, 1,  1, 0, 4'h0, 8'd0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            @(negedge clk_i);
            drive(v.awv, v.aws, v.awl, v.mawr, v.wv, v.ws, v.wl, v.mwr);
            rst_i    = v.rst;
            s_w_pl_i = {8'h5A, 32'(i), 32'hBEEF_0001};
            #1;
            if (v.chk) begin
                check($sformatf("row%0d s_aw_ready", i), 128'(s_aw_ready_o), 128'(v.e_awr));
                check($sformatf("row%0d m_aw_valid", i), 128'(m_aw_valid_o), 128'(v.e_mawv));
                check($sformatf("row%0d m_w_valid", i),  128'(m_w_valid_o),  128'(v.e_mwv));
                check($sformatf("row%0d s_w_ready", i),  128'(s_w_ready_o),  128'(v.e_swr));
                check($sformatf("row%0d m_w_last", i),   128'(m_w_last_o),   128'(v.e_last));
                check($sformatf("row%0d err", i),        128'(err_o),        128'(v.e_err));
                if (v.e_mawv) begin
                    check($sformatf("row%0d m_aw_src", i), 128'(m_aw_src_o), 128'(v.e_src));
                    check($sformatf("row%0d m_aw_len", i), 128'(m_aw_len_o), 128'(v.e_len));
                    check($sformatf("row%0d m_aw_pl", i),  128'(m_aw_pl_o),  128'(aw_pl(v.e_src, v.e_len)));
                end
                if (v.e_mwv)
                    check($sformatf("row%0d m_w_pl", i), 128'(m_w_pl_o),
                          128'({8'h5A, 32'(i), 32'hBEEF_0001}));
            end
        end

        // Push and last-beat pop together at occupancy DEPTH-1 keeps occupancy at DEPTH-1.
        @(negedge clk_i); drive(1, 4'h1, 8'd0, 1, 0, 4'h0, 0, 1);
        @(negedge clk_i); drive(1, 4'h2, 8'd0, 1, 0, 4'h0, 0, 1);
        @(negedge clk_i); drive(1, 4'h3, 8'd0, 1, 0, 4'h0, 0, 1);
        @(negedge clk_i); drive(1, 4'h4, 8'd0, 1, 1, 4'h1, 1, 1);
        #1;
        check("pushpop s_aw_ready", 128'(s_aw_ready_o), 128'(1'b1));
        check("pushpop m_w_valid",  128'(m_w_valid_o),  128'(1'b1));
        check("pushpop m_w_last",   128'(m_w_last_o),   128'(1'b1));
        @(negedge clk_i); drive(1, 4'h5, 8'd0, 0, 0, 4'h0, 0, 1);
        #1;
        check("occ3 s_aw_ready", 128'(s_aw_ready_o), 128'(1'b1));
        @(negedge clk_i); drive(0, 4'h0, 8'd0, 0, 0, 4'h0, 0, 1);
        #1;
        check("occ4 s_aw_ready", 128'(s_aw_ready_o), 128'(1'b0));
        check("occ4 err",        128'(err_o),        128'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
